// File: rtl/reproductor_pkg.sv
// Shared types and timing constants for the melody playback controller.
package reproductor_pkg;

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    NOTA     = 2'd1,
    SILENCIO = 2'd2,
    PAUSADO  = 2'd3
  } estado_t;

  localparam int unsigned CLOCK_FREQUENCY = 12000000;
  localparam int unsigned ANCHO_TONO      = 16;

  function automatic int unsigned ms_a_ciclos(input int unsigned ms);
    return (CLOCK_FREQUENCY / 1000) * ms;
  endfunction

  localparam int unsigned T_NOTA_DEF        = ms_a_ciclos(250);
  localparam int unsigned T_SILENCIO_DEF    = ms_a_ciclos(20);
  localparam int unsigned ULTIMO_INDICE_DEF = 29;
  localparam int unsigned ANCHO_T_DEF       = 22;

endpackage

// File: rtl/reproductor_melodia_divisor_tono.sv
// Tone divider: counts to half_period-1, then toggles the registered square wave.
module divisor_tono
  import reproductor_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_enable,
  input  logic                  i_clear,
  input  logic                  i_mute,
  input  logic [ANCHO_TONO-1:0] i_half_period,
  output logic                  o_onda
);

  logic [ANCHO_TONO-1:0] r_cuenta;
  logic                  r_onda;
  logic                  w_limite;

  // A half-period shrinking below the current count still toggles on this cycle.
  always_comb begin
    w_limite = 1'b0;
    if (i_half_period != '0)
      w_limite = (r_cuenta >= (i_half_period - 1'b1));
  end

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cuenta <= '0;
      r_onda   <= 1'b0;
    end else if (i_mute) begin
      r_onda   <= 1'b0;
    end else if (i_enable) begin
      if (w_limite) begin
        r_cuenta <= '0;
        r_onda   <= ~r_onda;
      end else begin
        r_cuenta <= r_cuenta + 1'b1;
      end
    end
  end

  assign o_onda = r_onda;

endmodule

// File: rtl/reproductor_melodia.sv
// Melody playback FSM: steps the note index, times notes and gaps, drives the buzzer.
module reproductor_melodia
  import reproductor_pkg::*;
#(
  parameter int unsigned T_NOTA        = T_NOTA_DEF,
  parameter int unsigned T_SILENCIO    = T_SILENCIO_DEF,
  parameter int unsigned ULTIMO_INDICE = ULTIMO_INDICE_DEF,
  parameter int unsigned ANCHO_T       = ANCHO_T_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  play,
  input  logic                  pausa,
  input  logic                  stop,
  input  logic                  bucle,
  input  logic [ANCHO_TONO-1:0] nota,
  output logic [4:0]            indice,
  output logic                  buzzer,
  output logic                  sonando,
  output logic                  fin
);

  localparam logic [ANCHO_T-1:0] L_FIN_NOTA     = ANCHO_T'(T_NOTA - 1);
  localparam logic [ANCHO_T-1:0] L_FIN_SILENCIO = ANCHO_T'(T_SILENCIO - 1);
  localparam logic [5:0]         L_ULTIMO       = 6'(ULTIMO_INDICE);

  estado_t            r_estado, w_estado_sig;
  estado_t            r_guardado, w_guardado_sig;
  logic [4:0]         r_indice, w_indice_sig;
  logic [ANCHO_T-1:0] r_dur, w_dur_sig;
  logic               r_fin, w_fin_sig;
  logic               r_sonando;
  logic               w_fin_cancion;
  logic               w_tono_en, w_tono_clr, w_mute;
  logic               w_onda;

  assign w_fin_cancion = (nota == '0) || ({1'b0, r_indice} > L_ULTIMO);

  always_comb begin
    w_estado_sig   = r_estado;
    w_guardado_sig = r_guardado;
    w_indice_sig   = r_indice;
    w_dur_sig      = r_dur;
    w_fin_sig      = 1'b0;
    w_tono_en      = 1'b0;
    w_tono_clr     = 1'b0;
    w_mute         = 1'b0;
    if (stop) begin
      w_estado_sig = REPOSO;
      w_indice_sig = '0;
      w_dur_sig    = '0;
      w_tono_clr   = 1'b1;
    end else begin
      unique case (r_estado)
        REPOSO: begin
          w_indice_sig = '0;
          w_dur_sig    = '0;
          w_tono_clr   = 1'b1;
          if (play) w_estado_sig = NOTA;
        end
        NOTA: begin
          // Pause keeps both counters so the note resumes exactly where it stopped.
          if (pausa) begin
            w_estado_sig   = PAUSADO;
            w_guardado_sig = NOTA;
            w_mute         = 1'b1;
          end else if (w_fin_cancion) begin
            w_indice_sig = '0;
            w_dur_sig    = '0;
            w_tono_clr   = 1'b1;
            if (!bucle) begin
              w_estado_sig = REPOSO;
              w_fin_sig    = 1'b1;
            end
          end else if (r_dur == L_FIN_NOTA) begin
            w_estado_sig = SILENCIO;
            w_dur_sig    = '0;
            w_tono_clr   = 1'b1;
          end else begin
            w_dur_sig = r_dur + 1'b1;
            w_tono_en = 1'b1;
          end
        end
        SILENCIO: begin
          if (pausa) begin
            w_estado_sig   = PAUSADO;
            w_guardado_sig = SILENCIO;
            w_mute         = 1'b1;
          end else if (r_dur == L_FIN_SILENCIO) begin
            w_estado_sig = NOTA;
            w_indice_sig = r_indice + 1'b1;
            w_dur_sig    = '0;
            w_tono_clr   = 1'b1;
          end else begin
            w_dur_sig = r_dur + 1'b1;
          end
        end
        PAUSADO: begin
          w_mute = 1'b1;
          if (pausa || play) w_estado_sig = r_guardado;
        end
        default: w_estado_sig = REPOSO;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado   <= REPOSO;
      r_guardado <= NOTA;
      r_indice   <= '0;
      r_dur      <= '0;
      r_fin      <= 1'b0;
      r_sonando  <= 1'b0;
    end else begin
      r_estado   <= w_estado_sig;
      r_guardado <= w_guardado_sig;
      r_indice   <= w_indice_sig;
      r_dur      <= w_dur_sig;
      r_fin      <= w_fin_sig;
      r_sonando  <= (w_estado_sig == NOTA) || (w_estado_sig == SILENCIO);
    end
  end

  divisor_tono u_divisor_tono (
    .clk           (clk),
    .rst           (rst),
    .i_enable      (w_tono_en),
    .i_clear       (w_tono_clr),
    .i_mute        (w_mute),
    .i_half_period (nota),
    .o_onda        (w_onda)
  );

  assign indice  = r_indice;
  assign buzzer  = w_onda;
  assign sonando = r_sonando;
  assign fin     = r_fin;

endmodule

// File: tb/tb_reproductor_melodia.sv
// Scoreboard bench: a song-position model predicts every cycle's outputs.
module tb_reproductor_melodia;

  localparam int unsigned TN       = 20;
  localparam int unsigned TS       = 4;
  localparam int unsigned NOTAS    = 5;
  localparam int unsigned NOTE_LEN = TN + TS;
  localparam int unsigned END_POS  = NOTAS * NOTE_LEN;

  localparam int unsigned M_IDLE   = 0;
  localparam int unsigned M_RUN    = 1;
  localparam int unsigned M_PAUSED = 2;

  typedef struct packed {
    logic [4:0] indice;
    logic       buzzer;
    logic       sonando;
    logic       fin;
    logic       bz_dc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        play = 1'b0, pausa = 1'b0, stop = 1'b0, bucle = 1'b0;
  logic [15:0] nota;
  logic [4:0]  indice;
  logic        buzzer, sonando, fin;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc   = 0;

  exp_t sb[$];

  int unsigned m_mode = M_IDLE;
  int unsigned m_pos  = 0;
  bit          m_dc   = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb nota = (indice < 5'd5) ? (16'(indice) + 16'd3) : 16'd0;

  reproductor_melodia #(
    .T_NOTA        (TN),
    .T_SILENCIO    (TS),
    .ULTIMO_INDICE (29),
    .ANCHO_T       (22)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .play    (play),
    .pausa   (pausa),
    .stop    (stop),
    .bucle   (bucle),
    .nota    (nota),
    .indice  (indice),
    .buzzer  (buzzer),
    .sonando (sonando),
    .fin     (fin)
  );

  task automatic chk(input string name, input int unsigned act, input int unsigned expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, expv);
    end
  endtask

  // Outputs while playing, from the song position alone.
  function automatic exp_t at_pos(input int unsigned pos, input bit dc);
    exp_t e;
    int unsigned k, r;
    e = '0;
    e.sonando = 1'b1;
    if (pos < END_POS) begin
      k = pos / NOTE_LEN;
      r = pos % NOTE_LEN;
      e.indice = 5'(k);
      e.buzzer = (r < TN) ? 1'((r / (k + 3)) % 2) : 1'b0;
      e.bz_dc  = dc && (r < TN);
    end else begin
      e.indice = 5'(NOTAS);
    end
    return e;
  endfunction

  function automatic exp_t paused_out(input int unsigned pos);
    exp_t e;
    e = at_pos(pos, 1'b0);
    e.buzzer  = 1'b0;
    e.sonando = 1'b0;
    return e;
  endfunction

  task automatic step(input bit p_play, input bit p_pausa, input bit p_stop, input bit p_rst);
    exp_t e;
    play = p_play; pausa = p_pausa; stop = p_stop; rst = p_rst;
    e = '0;
    if (p_rst || p_stop) begin
      m_mode = M_IDLE;
    end else if (m_mode == M_IDLE) begin
      if (p_play) begin
        m_mode = M_RUN; m_pos = 0; m_dc = 1'b0;
        e = at_pos(0, 1'b0);
      end
    end else if (m_mode == M_RUN) begin
      if (p_pausa) begin
        m_mode = M_PAUSED;
        e = paused_out(m_pos);
      end else if (m_pos == END_POS) begin
        if (bucle) begin
          m_pos = 0; m_dc = 1'b0;
          e = at_pos(0, 1'b0);
        end else begin
          m_mode = M_IDLE;
          e.fin = 1'b1;
        end
      end else begin
        m_pos++;
        if ((m_pos % NOTE_LEN) >= TN) m_dc = 1'b0;
        e = at_pos(m_pos, m_dc);
      end
    end else begin
      if (p_pausa || p_play) begin
        m_mode = M_RUN;
        m_dc = 1'b1;
        e = at_pos(m_pos, m_dc);
      end else begin
        e = paused_out(m_pos);
      end
    end
    @(posedge clk);
    sb.push_back(e);
    #1;
    play = 1'b0; pausa = 1'b0; stop = 1'b0; rst = 1'b0;
  endtask

  task automatic idle_steps(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_until_pos(input int unsigned target, input int unsigned budget);
    int unsigned n;
    n = 0;
    while (!(m_mode == M_RUN && m_pos == target) && n < budget) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    if (!(m_mode == M_RUN && m_pos == target)) begin
      tests++;
      fails++;
      $display("FAIL reach_pos cycle=%0d actual=%0d expected=%0d", cyc, m_pos, target);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("indice", indice, e.indice);
      chk("sonando", sonando, e.sonando);
      chk("fin", fin, e.fin);
      if (!e.bz_dc) chk("buzzer", buzzer, e.buzzer);
    end
  end

  initial begin : stimulus
    bit r_play, r_pausa, r_stop, r_rst;
    int unsigned r;

    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle_steps(2);

    // basic play through note 0 into note 1, then end without loop
    bucle = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle_steps(30);
    run_until_pos(END_POS, 200);
    idle_steps(4);

    // loop for three passes, then stop
    bucle = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle_steps(3 * (END_POS + 1) + 10);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    bucle = 1'b0;
    idle_steps(2);

    // pause at duration 10 of index 2, hold, resume with play
    step(1'b1, 1'b0, 1'b0, 1'b0);
    run_until_pos(2 * NOTE_LEN + 10, 200);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle_steps(49);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle_steps(20);

    // stop during the gap after index 3, then stop together with pausa
    run_until_pos(3 * NOTE_LEN + TN + 1, 200);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle_steps(2);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle_steps(5);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    idle_steps(2);

    // reset mid-note, play ignored while playing, pausa ignored while idle
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle_steps(7);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle_steps(2);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle_steps(3);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle_steps(3);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle_steps(3);

    // random command traffic
    for (int unsigned i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 199);
      r_play  = (r < 6);
      r_pausa = (r >= 6 && r < 10);
      r_stop  = (r == 10);
      r_rst   = (r == 11);
      if (m_mode == M_RUN && m_pos == END_POS) r_pausa = 1'b0;
      if (m_mode == M_IDLE && r_play) r_pausa = 1'b0;
      if ($urandom_range(0, 99) < 2) bucle = ~bucle;
      step(r_play, r_pausa, r_stop, r_rst);
    end

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain cycle=%0d actual=%0d expected=0", cyc, sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
